// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed 7-segment driver.
// All segment/anode values are active-low: a 0 lights the element.
package seg7_pkg;

  // Slot phase encoding (kept as plain constants for legacy tool flows)
  localparam logic [0:0] PH_GUARD   = 1'b0;
  localparam logic [0:0] PH_DISPLAY = 1'b1;

  // Everything dark
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Hex-to-segment table, seg[0]=a .. seg[6]=g, active-low.
  // Concatenation lists entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // One frame's worth of user inputs, captured together so a frame never tears
  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lz;
  } snap_t;

  // Nibble of slot idx; slot 0 is the rightmost digit
  function automatic logic [3:0] digit_at(input logic [15:0] d, input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = d[3:0];
      2'd1:    r = d[7:4];
      2'd2:    r = d[11:8];
      default: r = d[15:12];
    endcase
    return r;
  endfunction

  // Single low bit at position idx
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] r;
    r = AN_OFF;
    r[idx] = 1'b0;
    return r;
  endfunction

  // Leading-zero blank mask: a slot blanks only if it and every slot to its
  // left are zero. Slot 0 always shows, so a value of 0 still reads "0".
  function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic en);
    logic [3:0] m;
    m[3] = en && (d[15:12] == 4'h0);
    m[2] = m[3] && (d[11:8] == 4'h0);
    m[1] = m[2] && (d[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup
  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver. Each slot is a short all-dark
// guard (kills ghosting while anodes switch) followed by the lit period.
// Inputs are snapshotted once per frame, at the start of slot 0.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 131072,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DISP_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);

  generate
    if (BLANK_CYC < 1 || BLANK_CYC >= SCAN_DIV) begin : g_bad_params
      $error("seg7_scan_driver: need 1 <= BLANK_CYC < SCAN_DIV");
    end
  endgenerate

  logic [0:0]    phase_q, phase_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  snap_t         shadow_q, shadow_d;
  logic          capture;
  logic [3:0]    blank_d;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;

  // Slot sequencing: GUARD -> DISPLAY -> GUARD (next idx)
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    capture = 1'b0;
    if (phase_q == PH_GUARD) begin
      if (cnt_q == GUARD_LAST) begin
        phase_d = PH_DISPLAY;
        cnt_d   = '0;
        capture = (idx_q == 2'd0);
      end
    end else begin
      if (cnt_q == DISP_LAST) begin
        phase_d = PH_GUARD;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  // Next snapshot; the outputs are built from the post-edge view so the
  // capture cycle already shows the fresh values alongside frame_tick
  always_comb begin
    shadow_d = shadow_q;
    if (capture) begin
      shadow_d.digits   = digits;
      shadow_d.dp_mask  = dp_mask;
      shadow_d.blank_lz = blank_lz;
    end
  end

  // Digit selection and leading-zero mask for the slot about to be shown
  always_comb begin
    cur_digit = digit_at(shadow_d.digits, idx_d);
    blank_d   = lz_mask(shadow_d.digits, shadow_d.blank_lz);
  end

  seg7_decode u_decode (
    .hex (cur_digit),
    .seg (dec_seg)
  );

  // Sequencer state and snapshot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_GUARD;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Registered pad outputs, dark whenever in guard or reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= capture;
      if (phase_d == PH_DISPLAY) begin
        an  <= an_select(idx_d);
        seg <= blank_d[idx_d] ? SEG_BLANK : dec_seg;
        dp  <= ~shadow_d.dp_mask[idx_d];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 131072: clk cycles per digit slot (display + guard).
REQ-002 SHALL have parameter BLANK_CYC, default 16: guard cycles per slot with all anodes off; legal range 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 SHALL have port clk  input  1  system clock; the only clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port digits  input  16  four 4-bit hex digits; [3:0] is the rightmost digit (slot 0), [15:12] the leftmost (slot 3).
REQ-006 SHALL have port dp_mask  input  4  bit i=1 lights the decimal point of slot i.
REQ-007 SHALL have port blank_lz  input  1  1 enables leading-zero blanking.
REQ-008 SHALL have port an  output  4  active-low anode enables; an[i] drives slot i.
REQ-009 SHALL have port seg  output  7  active-low segments; seg[0]=a through seg[6]=g.
REQ-010 SHALL have port dp  output  1  active-low decimal point.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-012 SHALL run a two-phase slot FSM, GUARD then DISPLAY, with a slot index idx cycling 0,1,2,3,0.
REQ-013 SHALL hold GUARD for exactly BLANK_CYC cycles with an=1111, seg=1111111 and dp=1.
REQ-014 SHALL hold DISPLAY for exactly SCAN_DIV-BLANK_CYC cycles with an low only at bit idx, seg=decode(shadow digit idx) and dp=~shadow_dp[idx].
REQ-015 SHALL advance idx by 1 modulo 4 on the DISPLAY-to-GUARD transition; a full frame therefore lasts 4*SCAN_DIV cycles.
REQ-016 SHALL capture digits, dp_mask and blank_lz into shadow registers on the GUARD-to-DISPLAY transition when idx=0, and only then.
REQ-017 SHALL assert frame_tick for exactly the one cycle in which that capture occurs; input changes at any other time SHALL NOT affect the outputs until the next capture (no tearing).
REQ-018 SHALL decode hex 0-F as 0-9 and A,b,C,d,E,F using the standard active-low patterns, e.g. 0=1000000, 1=1111001, 8=0000000, F=0001110.
REQ-019 With shadow blank_lz=1, SHALL blank slot 3 when its digit is 0; slot 2 when slots 3 and 2 are both 0; slot 1 when slots 3, 2 and 1 are all 0; slot 0 SHALL never be blanked.
REQ-020 A blanked slot SHALL drive seg=1111111 while its anode is still driven low, and dp SHALL still follow dp_mask.
REQ-021 an, seg, dp and frame_tick SHALL all be registered outputs, changing only on a clk edge, and an SHALL never have more than one bit low.

Reset
REQ-022 While rst=0, outputs SHALL immediately be an=1111, seg=1111111, dp=1, frame_tick=0.
REQ-023 While rst=0, internal state SHALL be phase=GUARD, idx=0, cycle counter=0 and shadow registers all 0.
REQ-024 After rst is released, SHALL spend BLANK_CYC cycles in GUARD, then capture (frame_tick=1) and display slot 0.
REQ-025 Reset asserted mid-slot SHALL abort the slot at once; no partial snapshot is retained.

Structure
REQ-026 Shared package seg7_pkg SHALL hold the 16-entry hex-to-segment constant table, the blank pattern 7'b1111111 and the anodes-off pattern 4'b1111.
REQ-027 SHALL instantiate one combinational sub-module seg7_decode (4-bit in, 7-bit active-low out) driven from the shadow digit selected by idx.
REQ-028 The cycle counter SHALL be $clog2(SCAN_DIV) bits wide; parameter legality SHALL be checked at elaboration.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-029 Reset release, digits=16'h1234, dp_mask=0100, blank_lz=0 -> 2 guard cycles, frame_tick pulse, then per slot an sequence 1110(seg 0011001), 1101(0110000), 1011(0100100, dp=0), 0111(1111001); each slot has 6 lit cycles and 2 guard cycles.
REQ-030 digits=16'h0007, blank_lz=1 -> slots 3, 2 and 1 show seg=1111111 with anode low; slot 0 shows 1111000; with blank_lz=0 the same slots show 1000000.
REQ-031 Change digits during slot 2 of a frame -> displayed values are unchanged until the next frame_tick, then new values appear starting at slot 0.
REQ-032 Assert rst during the DISPLAY phase of slot 2 -> same cycle an=1111, seg=1111111, dp=1; after release the sequence restarts per REQ-024.
REQ-033 Free-run 3 frames -> frame_tick period is exactly 32 cycles, no cycle has two anodes low, and every idx change is preceded by exactly 2 cycles with an=1111.
